// File: rtl/mem_rr_arb.sv
// ---------------------------------------------------------------------------
// mem_rr_arb
//   Round-robin arbiter sharing one single-ported SRAM master port among
//   NREQ requesters. Grant selection is combinational from the request
//   vector and a rotating priority pointer. A request that meets a memory
//   stall is locked until it is accepted. Read data is steered back with a
//   one-cycle tag (rd_pend/rd_idx), so the return does not depend on the
//   grant in the return cycle.
//
// Ports
//   clk, rst            : clock, synchronous active-high reset
//   req_cs/req_we       : per-requester request and write flag
//   req_addr/byte/di    : packed per-requester attributes, slot i at [i*W +: W]
//   req_busy            : 1 = requester not accepted this cycle, hold attributes
//   req_do/req_rvalid   : shared read data and one-hot return qualifier
//   m_cs/we/addr/byte/di: memory-side request (all zero when idle)
//   m_do/m_busy         : memory read data (one cycle after accept) and stall
// ---------------------------------------------------------------------------
module mem_rr_arb #(
    parameter int NREQ = 3,
    parameter int AW   = 32,
    parameter int DW   = 32
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NREQ-1:0]        req_cs,
    input  logic [NREQ-1:0]        req_we,
    input  logic [NREQ*AW-1:0]     req_addr,
    input  logic [NREQ*(DW/8)-1:0] req_byte,
    input  logic [NREQ*DW-1:0]     req_di,
    output logic [NREQ-1:0]        req_busy,
    output logic [DW-1:0]          req_do,
    output logic [NREQ-1:0]        req_rvalid,
    output logic                   m_cs,
    output logic                   m_we,
    output logic [AW-1:0]          m_addr,
    output logic [DW/8-1:0]        m_byte,
    output logic [DW-1:0]          m_di,
    input  logic [DW-1:0]          m_do,
    input  logic                   m_busy
);

    localparam int BW = DW / 8;
    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

    logic [PW-1:0] ptr;
    logic [PW-1:0] lk_idx;
    logic [PW-1:0] rd_idx;
    logic          lock;
    logic          rd_pend;

    logic [PW-1:0] cand;
    logic [PW-1:0] scan_idx;
    logic [PW-1:0] nxt_ptr;
    logic          found;
    logic          accept;
    int            scan;

    logic [AW-1:0] addr_a [NREQ];
    logic [BW-1:0] byte_a [NREQ];
    logic [DW-1:0] di_a   [NREQ];

    for (genvar g = 0; g < NREQ; g++) begin : g_unpack
        assign addr_a[g] = req_addr[g*AW +: AW];
        assign byte_a[g] = req_byte[g*BW +: BW];
        assign di_a[g]   = req_di[g*DW +: DW];
    end

    // Candidate selection. A lock only holds while its owner keeps req_cs
    // high; if the owner withdraws, the rotating scan runs in the same cycle.
    always_comb begin
        found    = 1'b0;
        cand     = '0;
        scan     = 0;
        scan_idx = '0;
        if (lock && req_cs[lk_idx]) begin
            found = 1'b1;
            cand  = lk_idx;
        end else begin
            for (int k = 0; k < NREQ; k++) begin
                scan = int'(ptr) + k;
                if (scan >= NREQ) begin
                    scan = scan - NREQ;
                end
                scan_idx = PW'(scan);
                if (!found && req_cs[scan_idx]) begin
                    found = 1'b1;
                    cand  = scan_idx;
                end
            end
        end
    end

    assign m_cs    = found & ~rst;
    assign accept  = m_cs & ~m_busy;
    assign nxt_ptr = (cand == PW'(NREQ - 1)) ? '0 : cand + 1'b1;

    // Memory-side attributes are forced to zero when nothing is granted.
    always_comb begin
        m_we   = 1'b0;
        m_addr = '0;
        m_byte = '0;
        m_di   = '0;
        if (m_cs) begin
            m_we   = req_we[cand];
            m_addr = addr_a[cand];
            m_byte = byte_a[cand];
            m_di   = di_a[cand];
        end
    end

    // Everyone requesting is busy except the requester accepted this cycle;
    // during a stall that includes the candidate itself.
    always_comb begin
        req_busy = '0;
        for (int i = 0; i < NREQ; i++) begin
            req_busy[i] = req_cs[i] & ~(accept && (cand == PW'(i)));
        end
    end

    assign req_do     = m_do;
    assign req_rvalid = (rd_pend && !rst) ? (NREQ'(1) << rd_idx) : '0;

    // Control state: pointer only moves on an accepted access, so stall
    // cycles never cost a waiting requester its turn.
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr     <= '0;
            lock    <= 1'b0;
            rd_pend <= 1'b0;
            rd_idx  <= '0;
        end else begin
            rd_pend <= accept & ~m_we;
            if (accept) begin
                ptr  <= nxt_ptr;
                lock <= 1'b0;
                if (!m_we) begin
                    rd_idx <= cand;
                end
            end else if (m_cs) begin
                lock <= 1'b1;
            end else begin
                lock <= 1'b0;
            end
        end
    end

    // Lock owner; only meaningful while lock is set, so it needs no reset.
    always_ff @(posedge clk) begin
        if (m_cs && m_busy) begin
            lk_idx <= cand;
        end
    end

endmodule

// File: tb/tb_mem_rr_arb.sv
module tb_mem_rr_arb;

    localparam int NREQ = 3;
    localparam int AW   = 32;
    localparam int DW   = 32;
    localparam int BW   = DW / 8;

    logic                 clk = 1'b0;
    logic                 rst;
    logic [NREQ-1:0]      req_cs;
    logic [NREQ-1:0]      req_we;
    logic [NREQ*AW-1:0]   req_addr;
    logic [NREQ*BW-1:0]   req_byte;
    logic [NREQ*DW-1:0]   req_di;
    logic [NREQ-1:0]      req_busy;
    logic [DW-1:0]        req_do;
    logic [NREQ-1:0]      req_rvalid;
    logic                 m_cs;
    logic                 m_we;
    logic [AW-1:0]        m_addr;
    logic [BW-1:0]        m_byte;
    logic [DW-1:0]        m_di;
    logic [DW-1:0]        m_do;
    logic                 m_busy;

    // Requester-side stimulus as one record per requester
    logic          cs_a   [NREQ];
    logic          we_a   [NREQ];
    logic [AW-1:0] addr_a [NREQ];
    logic [BW-1:0] byte_a [NREQ];
    logic [DW-1:0] di_a   [NREQ];

    // Reference model state
    int              mptr;
    bit              mlock;
    int              mlk;
    bit              mrd_pend;
    int              mrd_idx;
    int              cur_g;
    bit              cur_acc;
    logic [NREQ-1:0] e_busy;
    int              wait_n [NREQ];

    int n_cmp = 0;
    int n_err = 0;
    int t2_seq [6] = '{0, 1, 2, 0, 1, 2};

    mem_rr_arb #(.NREQ(NREQ), .AW(AW), .DW(DW)) dut (
        .clk(clk), .rst(rst),
        .req_cs(req_cs), .req_we(req_we), .req_addr(req_addr),
        .req_byte(req_byte), .req_di(req_di),
        .req_busy(req_busy), .req_do(req_do), .req_rvalid(req_rvalid),
        .m_cs(m_cs), .m_we(m_we), .m_addr(m_addr), .m_byte(m_byte), .m_di(m_di),
        .m_do(m_do), .m_busy(m_busy)
    );

    always #5 clk = ~clk;

    always_comb begin
        req_cs   = '0;
        req_we   = '0;
        req_addr = '0;
        req_byte = '0;
        req_di   = '0;
        for (int i = 0; i < NREQ; i++) begin
            req_cs[i]            = cs_a[i];
            req_we[i]            = we_a[i];
            req_addr[i*AW +: AW] = addr_a[i];
            req_byte[i*BW +: BW] = byte_a[i];
            req_di[i*DW +: DW]   = di_a[i];
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_req(input int i, input logic cs, input logic we, input logic [AW-1:0] a,
                           input logic [BW-1:0] b, input logic [DW-1:0] d);
        cs_a[i]   = cs;
        we_a[i]   = we;
        addr_a[i] = a;
        byte_a[i] = b;
        di_a[i]   = d;
    endtask

    task automatic idle_all();
        for (int i = 0; i < NREQ; i++) set_req(i, 1'b0, 1'b0, '0, '0, '0);
    endtask

    // Settle, predict every output from the model, compare.
    task automatic eval();
        int g;
        logic [NREQ-1:0] erv;
        #1;
        g = -1;
        if (!rst) begin
            if (mlock && cs_a[mlk]) g = mlk;
            else begin
                for (int k = 0; k < NREQ; k++) begin
                    if (g < 0 && cs_a[(mptr + k) % NREQ]) g = (mptr + k) % NREQ;
                end
            end
        end
        cur_g   = g;
        cur_acc = (g >= 0) && !m_busy;
        for (int i = 0; i < NREQ; i++) e_busy[i] = cs_a[i] && !(cur_acc && g == i);
        erv = (!rst && mrd_pend) ? NREQ'(1 << mrd_idx) : '0;
        chk("m_cs",   m_cs,   (g >= 0));
        chk("m_we",   m_we,   (g >= 0) ? we_a[g]   : 1'b0);
        chk("m_addr", m_addr, (g >= 0) ? addr_a[g] : '0);
        chk("m_byte", m_byte, (g >= 0) ? byte_a[g] : '0);
        chk("m_di",   m_di,   (g >= 0) ? di_a[g]   : '0);
        chk("req_busy",   req_busy,   e_busy);
        chk("req_rvalid", req_rvalid, erv);
        chk("req_do",     req_do,     m_do);
    endtask

    // Clock edge: advance the model with what was presented before the edge.
    task automatic tick();
        @(posedge clk);
        if (rst) begin
            mptr = 0; mlock = 0; mrd_pend = 0; mrd_idx = 0;
            for (int i = 0; i < NREQ; i++) wait_n[i] = 0;
        end else begin
            if (cur_acc) begin
                for (int i = 0; i < NREQ; i++)
                    if (i != cur_g && cs_a[i]) wait_n[i]++;
                chk("fairness", (wait_n[cur_g] <= NREQ - 1), 1'b1);
                wait_n[cur_g] = 0;
            end
            for (int i = 0; i < NREQ; i++) if (!cs_a[i]) wait_n[i] = 0;
            mrd_pend = cur_acc && !we_a[cur_g];
            if (cur_acc) begin
                mrd_idx = cur_g;
                mptr    = (cur_g + 1) % NREQ;
                mlock   = 0;
            end else if (cur_g >= 0) begin
                mlock = 1;
                mlk   = cur_g;
            end else begin
                mlock = 0;
            end
        end
        #1;
    endtask

    initial begin
        mptr = 0; mlock = 0; mlk = 0; mrd_pend = 0; mrd_idx = 0;
        for (int i = 0; i < NREQ; i++) wait_n[i] = 0;
        idle_all();
        rst = 1'b1; m_busy = 1'b0; m_do = '0;
        @(posedge clk); #1;

        // Reset: all requesting, nothing goes to memory
        for (int i = 0; i < NREQ; i++) set_req(i, 1'b1, 1'b0, 32'h10 * i, 4'hf, '0);
        eval(); chk("rst_mcs", m_cs, 1'b0); tick();
        eval(); chk("rst_busy", req_busy, 3'b111); chk("rst_rvalid", req_rvalid, 3'b000); tick();

        // Single read from requester 0
        rst = 1'b0; idle_all();
        set_req(0, 1'b1, 1'b0, 32'h100, 4'hf, '0);
        eval(); chk("t1_busy0", req_busy[0], 1'b0); chk("t1_addr", m_addr, 32'h100); tick();
        idle_all(); m_do = 32'hDEADBEEF;
        eval(); chk("t1_rvalid", req_rvalid, 3'b001); chk("t1_do", req_do, 32'hDEADBEEF); tick();

        // Continuous contention from reset
        rst = 1'b1; eval(); tick(); rst = 1'b0;
        set_req(0, 1'b1, 1'b0, 32'h1000, 4'hf, 32'h0);
        set_req(1, 1'b1, 1'b1, 32'h2000, 4'b0011, 32'hA5A5_1111);
        set_req(2, 1'b1, 1'b0, 32'h3000, 4'hf, 32'h0);
        for (int n = 0; n < 6; n++) begin
            m_do = $urandom;
            eval();
            chk("t2_grant", m_addr, 32'h1000 * (t2_seq[n] + 1) + 32'h10 * (n / 3));
            chk("t2_busy", req_busy, ~(3'b001 << t2_seq[n]) & 3'b111);
            if (n == 1) begin
                chk("t2_byte", m_byte, 4'b0011);
                chk("t2_we", m_we, 1'b1);
            end
            tick();
            we_a[t2_seq[n]]   = 1'b0;
            byte_a[t2_seq[n]] = 4'hf;
            addr_a[t2_seq[n]] = addr_a[t2_seq[n]] + 32'h10;
        end

        // Stall locks requester 1 against a later higher-priority request
        idle_all(); eval(); tick();
        set_req(1, 1'b1, 1'b0, 32'h3100, 4'hf, '0); m_busy = 1'b1;
        eval(); chk("t3_stall0", m_addr, 32'h3100); tick();
        set_req(0, 1'b1, 1'b0, 32'h3000, 4'hf, '0);
        for (int n = 0; n < 2; n++) begin
            eval(); chk("t3_locked", m_addr, 32'h3100); chk("t3_busy", req_busy, 3'b011); tick();
        end
        m_busy = 1'b0;
        eval(); chk("t3_grant", m_addr, 32'h3100); chk("t3_busy_g", req_busy, 3'b001); tick();
        cs_a[1] = 1'b0; set_req(2, 1'b1, 1'b0, 32'h3200, 4'hf, '0);
        eval(); chk("t3_ptr2", m_addr, 32'h3200); tick();
        cs_a[2] = 1'b0;
        eval(); chk("t3_then0", m_addr, 32'h3000); tick();

        // Read from 2 then write from 0
        idle_all(); set_req(2, 1'b1, 1'b0, 32'h4200, 4'hf, '0);
        eval(); tick();
        idle_all(); set_req(0, 1'b1, 1'b1, 32'h4000, 4'hf, 32'h1234_5678); m_do = 32'hCAFE_0002;
        eval(); chk("t4_rvalid", req_rvalid, 3'b100); chk("t4_busy", req_busy, 3'b000); tick();
        idle_all();
        eval(); chk("t4_no_rvalid", req_rvalid, 3'b000); tick();

        // Reset while locked
        set_req(2, 1'b1, 1'b0, 32'h5200, 4'hf, '0); m_busy = 1'b1;
        eval(); tick();
        rst = 1'b1; set_req(0, 1'b1, 1'b0, 32'h5000, 4'hf, '0);
        eval(); chk("t5_mcs", m_cs, 1'b0); chk("t5_busy", req_busy, 3'b101); tick();
        rst = 1'b0; m_busy = 1'b0; set_req(1, 1'b1, 1'b0, 32'h5100, 4'hf, '0);
        eval(); chk("t5_first0", m_addr, 32'h5000); chk("t5_busy_r", req_busy, 3'b110); tick();
        // Reset with a read return pending
        idle_all(); set_req(1, 1'b1, 1'b0, 32'h5100, 4'hf, '0);
        eval(); tick();
        idle_all(); rst = 1'b1;
        eval(); chk("t5_rst_rv", req_rvalid, 3'b000); chk("t5_rst_mcs", m_cs, 1'b0); tick();
        rst = 1'b0;
        eval(); chk("t5_no_ret", req_rvalid, 3'b000); tick();

        // Locked requester withdraws
        set_req(1, 1'b1, 1'b0, 32'h6100, 4'hf, '0); m_busy = 1'b1;
        eval(); tick();
        cs_a[1] = 1'b0; set_req(2, 1'b1, 1'b1, 32'h6200, 4'h3, 32'h77); m_busy = 1'b0;
        eval(); chk("t6_rearb", m_addr, 32'h6200); chk("t6_mcs", m_cs, 1'b1); tick();
        idle_all(); set_req(0, 1'b1, 1'b0, 32'h6000, 4'hf, '0); set_req(1, 1'b1, 1'b0, 32'h6100, 4'hf, '0);
        eval(); chk("t6_unlocked", m_addr, 32'h6000); chk("t6_busy", req_busy, 3'b010); tick();
        idle_all(); eval(); tick();

        // Randomised traffic; busy requesters hold their attributes
        for (int c = 0; c < 400; c++) begin
            rst    = ($urandom_range(0, 99) < 2);
            m_busy = ($urandom_range(0, 99) < 30);
            m_do   = $urandom;
            for (int i = 0; i < NREQ; i++) begin
                if (!(cs_a[i] && e_busy[i])) begin
                    cs_a[i]   = ($urandom_range(0, 99) < 60);
                    we_a[i]   = 1'($urandom);
                    addr_a[i] = $urandom;
                    byte_a[i] = BW'($urandom);
                    di_a[i]   = $urandom;
                end
            end
            eval();
            tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
